// File: rtl/mvu_pe_acc.sv
// mvu_pe_acc: reduces SIMD lane products per beat and accumulates SF beats into one dot-product
//   clk      in   clock, state updates on rising edge
//   rst      in   synchronous active-high reset
//   in_v     in   input beat valid
//   in_rdy   out  input beat can be accepted
//   in_data  in   SIMD packed signed lane products, lane i at [i*TDstI +: TDstI]
//   out_v    out  out holds a completed dot-product
//   out_rdy  in   downstream accepts out
//   out      out  signed accumulated result
module mvu_pe_acc #(
    parameter int SIMD  = 4,
    parameter int TDstI = 16,
    parameter int TDstA = 24,
    parameter int SF    = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_v,
    output logic                    in_rdy,
    input  logic [SIMD*TDstI-1:0]   in_data,
    output logic                    out_v,
    input  logic                    out_rdy,
    output logic [TDstA-1:0]        out
);
    localparam int CW = SF > 1 ? $clog2(SF) : 1;
    localparam logic [CW-1:0] LAST = CW'(SF - 1);
    typedef enum logic {ACC, FULL} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] sf_cnt_q, sf_cnt_d;
    logic [TDstA-1:0] acc_q, acc_d, out_q, out_d, lane_sum, sum_new;
    logic accept, consume, done;
    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < SIMD; i++)
            lane_sum = lane_sum + TDstA'($signed(in_data[i*TDstI +: TDstI]));
    end
    assign accept  = in_v && in_rdy;
    assign consume = out_v && out_rdy;
    assign done    = accept && sf_cnt_q == LAST;
    // first beat of a fold restarts the sum rather than adding to the old one
    assign sum_new = (sf_cnt_q == '0 ? '0 : acc_q) + lane_sum;
    always_ff @(posedge clk) begin
        if (rst) state_q <= ACC;
        else     state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        if (state_q == ACC) state_d = done ? FULL : ACC;
        else                state_d = done ? FULL : (consume ? ACC : FULL);
    end
    // only the completing beat must wait for a stalled result; earlier beats of the next fold proceed
    always_comb begin
        out_v  = state_q == FULL;
        in_rdy = rst || !(sf_cnt_q == LAST && out_v && !out_rdy);
        out    = out_q;
    end
    always_comb begin
        acc_d    = accept ? sum_new : acc_q;
        sf_cnt_d = accept ? (sf_cnt_q == LAST ? '0 : sf_cnt_q + 1'b1) : sf_cnt_q;
        out_d    = done ? sum_new : out_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            sf_cnt_q <= '0;
            out_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            sf_cnt_q <= sf_cnt_d;
            out_q    <= out_d;
        end
    end
endmodule
